// File: rtl/encryption_layer_scheduler_pkg.sv
// Shared types and helpers for the layer scheduler.
// Holds the state enum, bit-depth limit, layer index type and key rotation helper.
package encryption_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISSUE,
    FEED,
    WAIT,
    NEXT,
    FIN
  } sched_state_e;

  localparam int MAX_BIT_DEPTH = 8;

  typedef logic [15:0] layer_idx_t;

  // Rotate left by whole bytes, one byte per layer, wrapping every 16 layers.
  function automatic logic [127:0] rotl_key(
    input logic [127:0] k,
    input layer_idx_t   layer
  );
    logic [6:0] sh;
    sh = 7'(layer * 8);
    return (k << sh) | (k >> (8'd128 - {1'b0, sh}));
  endfunction

endpackage

// File: rtl/encryption_layer_scheduler_if.sv
// Core-control and pixel-read bus between the scheduler and core/buffer.
// master: scheduler side (drives core_*, rd_valid, rd_addr); slave: core/buffer side.
interface encryption_layer_scheduler_if #(
  parameter int LW     = 3,
  parameter int ADDR_W = 16
);
  logic              core_start;
  logic [127:0]      core_key;
  logic [7:0]        core_depth;
  logic [LW-1:0]     core_layer;
  logic              core_done;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;

  modport master (
    output core_start, core_key, core_depth, core_layer,
    output rd_valid, rd_addr,
    input  core_done, rd_ready
  );

  modport slave (
    input  core_start, core_key, core_depth, core_layer,
    input  rd_valid, rd_addr,
    output core_done, rd_ready
  );
endinterface

// File: rtl/encryption_addr_gen.sv
// Row/column pixel counters producing the read address for one layer.
// Ports: clk, rst, clear, advance, layer in; last_px, rd_addr out.
module encryption_addr_gen
  import encryption_pkg::*;
#(
  parameter int MAX_Y  = 64,
  parameter int MAX_Z  = 64,
  parameter int ADDR_W = 16,
  parameter int LW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [LW-1:0]     layer,
  output logic              last_px,
  output logic [ADDR_W-1:0] rd_addr
);
  localparam int RW = (MAX_Y > 1) ? $clog2(MAX_Y) : 1;
  localparam int CW = (MAX_Z > 1) ? $clog2(MAX_Z) : 1;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          col_last;
  logic          row_last;

  assign col_last = (col == CW'(MAX_Z - 1));
  assign row_last = (row == RW'(MAX_Y - 1));
  assign last_px  = col_last && row_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign rd_addr = ADDR_W'(layer) * ADDR_W'(MAX_Y * MAX_Z)
                 + ADDR_W'(row) * ADDR_W'(MAX_Z)
                 + ADDR_W'(col);

endmodule

// File: rtl/encryption_layer_scheduler.sv
// Sequences layers of an image through one shared encryption core.
// Ports: clk, rst, start, abort, key, bit_depth in; busy, done, err out;
// bus (master): core start/key/depth/layer/done and rd valid/ready/addr.
// Option LAYER_KEY_ROTATE_EN: per-layer key rotated left by 8*layer bits.
module encryption_layer_scheduler
  import encryption_pkg::*;
#(
  parameter int MAX_X  = 8,
  parameter int MAX_Y  = 64,
  parameter int MAX_Z  = 64,
  parameter int ADDR_W = 16,
  parameter int TMO_W  = 16,
  localparam int LW    = (MAX_X > 1) ? $clog2(MAX_X) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key,
  input  logic [7:0]   bit_depth,
  output logic         busy,
  output logic         done,
  output logic         err,
  encryption_layer_scheduler_if.master bus
);
  sched_state_e     state;
  logic [127:0]     key_q;
  logic [7:0]       depth_q;
  logic [LW-1:0]    layer;
  logic [LW-1:0]    layer_nx;
  logic [127:0]     key_nx;
  logic [TMO_W-1:0] tmo;
  logic [TMO_W-1:0] tmo_nx;
  logic             advance;
  logic             last_px;

  assign busy           = (state != IDLE);
  assign advance        = bus.rd_valid && bus.rd_ready;
  assign tmo_nx         = tmo + TMO_W'(1);
  assign bus.core_layer = layer;

  // Layer about to be issued: 0 from LATCH, layer+1 from NEXT.
  assign layer_nx = (state == NEXT) ? layer + LW'(1) : '0;

`ifdef LAYER_KEY_ROTATE_EN
  assign key_nx = rotl_key(key_q, layer_idx_t'(layer_nx));
`else
  assign key_nx = key_q;
`endif

  encryption_addr_gen #(
    .MAX_Y  (MAX_Y),
    .MAX_Z  (MAX_Z),
    .ADDR_W (ADDR_W),
    .LW     (LW)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ISSUE),
    .advance (advance),
    .layer   (layer),
    .last_px (last_px),
    .rd_addr (bus.rd_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      done           <= 1'b0;
      err            <= 1'b0;
      key_q          <= '0;
      depth_q        <= '0;
      layer          <= '0;
      tmo            <= '0;
      bus.core_start <= 1'b0;
      bus.core_key   <= '0;
      bus.core_depth <= '0;
      bus.rd_valid   <= 1'b0;
    end else begin
      done           <= 1'b0;
      bus.core_start <= 1'b0;
      if (abort && state != IDLE) begin
        state        <= IDLE;
        bus.rd_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              key_q   <= key;
              depth_q <= bit_depth;
              state   <= LATCH;
            end
          end
          LATCH: begin
            err            <= 1'b0;
            layer          <= layer_nx;
            bus.core_depth <= depth_q;
            if (depth_q == 8'd0 || depth_q > 8'(MAX_BIT_DEPTH)) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              bus.core_start <= 1'b1;
              bus.core_key   <= key_nx;
              state          <= ISSUE;
            end
          end
          ISSUE: begin
            if (bus.core_done) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              bus.rd_valid <= 1'b1;
              state        <= FEED;
            end
          end
          FEED: begin
            if (bus.core_done) begin
              err          <= 1'b1;
              done         <= 1'b1;
              bus.rd_valid <= 1'b0;
              state        <= FIN;
            end else if (advance && last_px) begin
              bus.rd_valid <= 1'b0;
              tmo          <= '0;
              state        <= WAIT;
            end
          end
          WAIT: begin
            // Leaves after 2**TMO_W-1 cycles without core_done.
            if (bus.core_done) begin
              state <= NEXT;
            end else if (&tmo_nx) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              tmo <= tmo_nx;
            end
          end
          NEXT: begin
            if (layer == LW'(MAX_X - 1)) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              layer          <= layer_nx;
              bus.core_start <= 1'b1;
              bus.core_key   <= key_nx;
              state          <= ISSUE;
            end
          end
          FIN: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
